// File: rtl/hyperbus_cfg_pkg.sv
// hyperbus_cfg_pkg: shared types for the hyperbus config sequencer and its reg-bus mux.
package hyperbus_cfg_pkg;
  localparam int CFG_AW = 32;
  localparam int CFG_DW = 32;
  localparam int CFG_SW = 4;
  typedef enum logic [2:0] {INIT, WRITE, POLL, PASS, FAIL} cfg_seq_state_e;
  typedef struct packed {
    logic [CFG_AW-1:0] addr;
    logic              write;
    logic [CFG_DW-1:0] wdata;
    logic [CFG_SW-1:0] wstrb;
    logic              valid;
  } reg_req_t;
  typedef struct packed {
    logic [CFG_DW-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;
endpackage

// File: rtl/hyperbus_cfg_sequencer.sv
// hyperbus_cfg_sequencer: boot-time register table writer and status poller, then SoC passthrough.
module hyperbus_cfg_sequencer
  import hyperbus_cfg_pkg::*;
#(
  parameter int unsigned           NUM_CFG   = 4,
  parameter logic [NUM_CFG*32-1:0] CFG_ADDR  = {NUM_CFG{32'h0}},
  parameter logic [NUM_CFG*32-1:0] CFG_DATA  = {NUM_CFG{32'h0}},
  parameter logic [31:0]           POLL_ADDR = 32'h0,
  parameter logic [31:0]           POLL_MASK = 32'h1,
  parameter int unsigned           MAX_POLLS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] soc_addr_i,
  input  logic        soc_write_i,
  input  logic [31:0] soc_wdata_i,
  input  logic [3:0]  soc_wstrb_i,
  input  logic        soc_valid_i,
  output logic        soc_ready_o,
  output logic [31:0] soc_rdata_o,
  output logic        soc_error_o,
  output logic [31:0] cfg_addr_o,
  output logic        cfg_write_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  output logic        cfg_valid_o,
  input  logic        cfg_ready_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic        cfg_error_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [4:0]  err_idx_o
);
  localparam int unsigned PW = $clog2(MAX_POLLS + 1);

  cfg_seq_state_e state_q, state_d;
  logic [4:0]     idx_q, idx_d, err_idx_q, err_idx_d;
  logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
  logic           start_pend_q, start_pend_d, done_q, done_d, error_q, error_d;
  logic [31:0]    tbl_addr, tbl_data;
  logic           passthru;
  reg_req_t       soc_req, seq_req, cfg_req;
  reg_rsp_t       cfg_rsp, soc_rsp;

  assign passthru = (state_q == PASS) || (state_q == FAIL);
  assign soc_req  = '{addr: soc_addr_i, write: soc_write_i, wdata: soc_wdata_i, wstrb: soc_wstrb_i, valid: soc_valid_i};
  assign cfg_rsp  = '{rdata: cfg_rdata_i, error: cfg_error_i, ready: cfg_ready_i};
  assign cfg_req  = passthru ? soc_req : seq_req;
  assign soc_rsp  = passthru ? cfg_rsp : '0;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    poll_cnt_d   = poll_cnt_q;
    start_pend_d = start_pend_q;
    err_idx_d    = err_idx_q;
    seq_req      = '0;
    tbl_addr     = '0;
    tbl_data     = '0;
    for (int i = 0; i < int'(NUM_CFG); i++) begin
      if (idx_q == 5'(i)) begin
        tbl_addr = CFG_ADDR[i*32 +: 32];
        tbl_data = CFG_DATA[i*32 +: 32];
      end
    end
    case (state_q)
      INIT: begin
        state_d = WRITE;
        idx_d   = '0;
      end
      WRITE: begin
        seq_req = '{addr: tbl_addr, write: 1'b1, wdata: tbl_data, wstrb: 4'hF, valid: 1'b1};
        if (cfg_rsp.ready) begin
          if (cfg_rsp.error) begin
            err_idx_d = idx_q;
            state_d   = FAIL;
          end else if (idx_q == 5'(NUM_CFG - 1)) begin
            poll_cnt_d = '0;
            state_d    = POLL;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      POLL: begin
        seq_req = '{addr: POLL_ADDR, write: 1'b0, wdata: '0, wstrb: '0, valid: 1'b1};
        if (cfg_rsp.ready) begin
          if (!cfg_rsp.error && (cfg_rsp.rdata & POLL_MASK) == POLL_MASK) begin
            state_d = PASS;
          end else begin
            poll_cnt_d = (poll_cnt_q == PW'(MAX_POLLS)) ? poll_cnt_q : poll_cnt_q + 1'b1;
            if (cfg_rsp.error || poll_cnt_d == PW'(MAX_POLLS)) begin
              err_idx_d = 5'(NUM_CFG);
              state_d   = FAIL;
            end
          end
        end
      end
      PASS, FAIL: begin
        start_pend_d = start_pend_q | start_i;
        // Never leave passthrough while a SoC request is mid-handshake.
        if (start_pend_q && !(soc_valid_i && !cfg_ready_i)) begin
          state_d      = INIT;
          start_pend_d = 1'b0;
          err_idx_d    = '0;
        end
      end
      default: state_d = INIT;
    endcase
    done_d  = (state_d == PASS);
    error_d = (state_d == FAIL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= INIT;
      idx_q        <= '0;
      poll_cnt_q   <= '0;
      start_pend_q <= 1'b0;
      err_idx_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      poll_cnt_q   <= poll_cnt_d;
      start_pend_q <= start_pend_d;
      err_idx_q    <= err_idx_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign cfg_addr_o  = cfg_req.addr;
  assign cfg_write_o = cfg_req.write;
  assign cfg_wdata_o = cfg_req.wdata;
  assign cfg_wstrb_o = cfg_req.wstrb;
  assign cfg_valid_o = cfg_req.valid;
  assign soc_ready_o = soc_rsp.ready;
  assign soc_rdata_o = soc_rsp.rdata;
  assign soc_error_o = soc_rsp.error;
  assign busy_o      = !passthru;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_idx_o   = err_idx_q;
endmodule

// File: tb/tb_hyperbus_cfg_sequencer.sv
// tb_hyperbus_cfg_sequencer: randomized macro/SoC stimulus against a transaction-level expectation model.
module tb_hyperbus_cfg_sequencer;
  localparam int          N  = 3;
  localparam logic [31:0] PA = 32'h10;
  localparam int          MP = 8;

  logic        clk_i = 0, rst_i = 0, start_i = 0;
  logic [31:0] soc_addr_i = 0, soc_wdata_i = 0;
  logic        soc_write_i = 0, soc_valid_i = 0;
  logic [3:0]  soc_wstrb_i = 0;
  logic        soc_ready_o, soc_error_o;
  logic [31:0] soc_rdata_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o, cfg_rdata_i;
  logic        cfg_write_o, cfg_valid_o, cfg_ready_i, cfg_error_i;
  logic [3:0]  cfg_wstrb_o;
  logic        busy_o, done_o, error_o;
  logic [4:0]  err_idx_o;

  hyperbus_cfg_sequencer #(
    .NUM_CFG(N), .CFG_ADDR({32'h2, 32'h1, 32'h0}), .CFG_DATA({32'h0000000F, 32'h5, 32'h1234}),
    .POLL_ADDR(PA), .POLL_MASK(32'h1), .MAX_POLLS(MP)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .soc_addr_i(soc_addr_i), .soc_write_i(soc_write_i), .soc_wdata_i(soc_wdata_i),
    .soc_wstrb_i(soc_wstrb_i), .soc_valid_i(soc_valid_i), .soc_ready_o(soc_ready_o),
    .soc_rdata_o(soc_rdata_o), .soc_error_o(soc_error_o),
    .cfg_addr_o(cfg_addr_o), .cfg_write_o(cfg_write_o), .cfg_wdata_o(cfg_wdata_o),
    .cfg_wstrb_o(cfg_wstrb_o), .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i),
    .cfg_rdata_i(cfg_rdata_i), .cfg_error_i(cfg_error_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_idx_o(err_idx_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] ta [N] = '{32'h0, 32'h1, 32'h2};
  logic [31:0] td [N] = '{32'h1234, 32'h5, 32'hF};

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } xfer_t;
  xfer_t log_q[$];

  int n_chk = 0, n_err = 0;
  int wcnt = 0, cur_wait = 0, polls_seen = 0;
  int fixed_wait = 0, wait_max = 0, fail_polls = 0;
  logic        err_en = 0;
  logic [31:0] err_addr = 0;
  logic [31:0] mem [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
  endfunction

  // Macro model: fixed/random wait states, status register that passes after fail_polls reads.
  assign cfg_ready_i = cfg_valid_o && (wcnt >= cur_wait);
  assign cfg_rdata_i = !cfg_ready_i ? 32'hDEADBEEF :
                       (cfg_addr_o == PA) ? ((polls_seen >= fail_polls) ? 32'h1 : 32'hFFFF_FFFE) :
                       mem[cfg_addr_o[4:0]];
  assign cfg_error_i = cfg_ready_i && err_en && (cfg_addr_o == err_addr);

  always @(posedge clk_i) begin
    if (rst_i) begin
      wcnt       <= 0;
      cur_wait   <= pick();
      polls_seen <= 0;
    end else if (cfg_ready_i) begin
      wcnt     <= 0;
      cur_wait <= pick();
      if (cfg_write_o && !cfg_error_i) mem[cfg_addr_o[4:0]] <= cfg_wdata_o;
      if (!cfg_write_o && cfg_addr_o == PA) polls_seen <= polls_seen + 1;
      log_q.push_back('{cfg_write_o, cfg_addr_o, cfg_wdata_o, cfg_wstrb_o});
    end else if (cfg_valid_o) begin
      wcnt <= wcnt + 1;
    end
  end

  logic        hold = 0, h_w = 0;
  logic [31:0] h_a = 0, h_d = 0;
  always @(posedge clk_i) begin
    hold <= !rst_i && cfg_valid_o && !cfg_ready_i;
    h_a  <= cfg_addr_o;
    h_d  <= cfg_wdata_o;
    h_w  <= cfg_write_o;
  end
  always @(negedge clk_i) begin
    if (hold && !rst_i) begin
      chk("hold_valid", 32'(cfg_valid_o), 32'd1);
      chk("hold_addr", cfg_addr_o, h_a);
      chk("hold_wdata", cfg_wdata_o, h_d);
      chk("hold_write", 32'(cfg_write_o), 32'(h_w));
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    #1 rst_i = 1;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_err_idx", 32'(err_idx_o), 32'd0);
    chk("rst_cfg_valid", 32'(cfg_valid_o), 32'd0);
    chk("rst_soc_ready", 32'(soc_ready_o), 32'd0);
    chk("rst_soc_error", 32'(soc_error_o), 32'd0);
    chk("rst_soc_rdata", soc_rdata_o, 32'd0);
    @(negedge clk_i);
    rst_i = 0;
    log_q.delete();
  endtask

  task automatic wait_end(input int budget, output int cyc);
    cyc = 0;
    while (!(done_o || error_o) && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("end_seen", 32'(done_o | error_o), 32'd1);
  endtask

  task automatic check_seq(input int off, input int nw, input int nr);
    for (int i = 0; i < nw; i++) begin
      if (log_q.size() > off + i) begin
        chk("seq_wr_flag", 32'(log_q[off+i].w), 32'd1);
        chk("seq_wr_addr", log_q[off+i].a, ta[i]);
        chk("seq_wr_data", log_q[off+i].d, td[i]);
        chk("seq_wr_strb", 32'(log_q[off+i].s), 32'hF);
      end
    end
    for (int j = 0; j < nr; j++) begin
      if (log_q.size() > off + nw + j) begin
        chk("seq_rd_flag", 32'(log_q[off+nw+j].w), 32'd0);
        chk("seq_rd_addr", log_q[off+nw+j].a, PA);
      end
    end
  endtask

  task automatic soc_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int n, output logic bz);
    @(posedge clk_i);
    #1;
    soc_valid_i = 1; soc_write_i = w; soc_addr_i = a; soc_wdata_i = d; soc_wstrb_i = 4'hF;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!soc_ready_o && n < 200);
    chk("soc_ready_seen", 32'(soc_ready_o), 32'd1);
    rd = soc_rdata_o;
    er = soc_error_o;
    bz = busy_o;
    @(posedge clk_i);
    #1;
    soc_valid_i = 0; soc_write_i = 0;
  endtask

  int          cyc, n, nw, nr, eidx, k;
  logic [31:0] rd, data;
  logic        er, bz, efail;

  initial begin
    // Zero-wait boot: three writes, one poll, PASS NUM_CFG+1 cycles after INIT exit.
    fixed_wait = 0; fail_polls = 0;
    do_reset();
    wait_end(100, cyc);
    chk("lat_zero_wait", 32'(cyc), 32'd5);
    chk("a_done", 32'(done_o), 32'd1);
    chk("a_error", 32'(error_o), 32'd0);
    chk("a_busy", 32'(busy_o), 32'd0);
    chk("a_len", 32'(log_q.size()), 32'd4);
    check_seq(0, 3, 1);

    fixed_wait = 2;
    do_reset();
    wait_end(200, cyc);
    chk("lat_wait2", 32'(cyc), 32'd13);
    chk("b_done", 32'(done_o), 32'd1);
    chk("b_len", 32'(log_q.size()), 32'd4);
    check_seq(0, 3, 1);

    fixed_wait = 0; fail_polls = 5;
    do_reset();
    wait_end(200, cyc);
    chk("c_done", 32'(done_o), 32'd1);
    chk("c_len", 32'(log_q.size()), 32'd9);
    check_seq(0, 3, 6);

    fail_polls = 100;
    do_reset();
    wait_end(200, cyc);
    chk("d_error", 32'(error_o), 32'd1);
    chk("d_done", 32'(done_o), 32'd0);
    chk("d_err_idx", 32'(err_idx_o), 32'd3);
    chk("d_len", 32'(log_q.size()), 32'(3 + MP));
    check_seq(0, 3, MP);

    fail_polls = 0; err_en = 1; err_addr = 32'h1;
    do_reset();
    wait_end(200, cyc);
    repeat (5) @(negedge clk_i);
    chk("e_error", 32'(error_o), 32'd1);
    chk("e_err_idx", 32'(err_idx_o), 32'd1);
    chk("e_len", 32'(log_q.size()), 32'd2);
    check_seq(0, 2, 0);
    soc_xfer(1'b0, 32'h2, 32'h0, rd, er, n, bz);
    chk("e_pt_rdata", rd, 32'hF);
    chk("e_pt_err", 32'(er), 32'd0);
    chk("e_pt_busy", 32'(bz), 32'd0);
    err_en = 0;

    // SoC write issued right after reset stalls until PASS, then lands unchanged.
    data = $urandom;
    do_reset();
    soc_xfer(1'b1, 32'h7, data, rd, er, n, bz);
    chk("f_stall_cycles", 32'(n), 32'd5);
    chk("f_busy", 32'(bz), 32'd0);
    chk("f_len", 32'(log_q.size()), 32'd5);
    check_seq(0, 3, 1);
    if (log_q.size() == 5) begin
      chk("f_wr_flag", 32'(log_q[4].w), 32'd1);
      chk("f_wr_addr", log_q[4].a, 32'h7);
      chk("f_wr_data", log_q[4].d, data);
    end
    soc_xfer(1'b0, 32'h7, 32'h0, rd, er, n, bz);
    chk("f_readback", rd, data);

    // Re-init requested while a slow SoC read is outstanding.
    fixed_wait = 3;
    do_reset();
    wait_end(300, cyc);
    chk("g_done", 32'(done_o), 32'd1);
    log_q.delete();
    fork
      soc_xfer(1'b0, 32'h0, 32'h0, rd, er, n, bz);
      begin
        @(posedge clk_i);
        #1 start_i = 1;
        @(posedge clk_i);
        #1 start_i = 0;
      end
    join
    chk("g_rdata", rd, 32'h1234);
    chk("g_cycles", 32'(n), 32'd4);
    chk("g_busy_at_rd", 32'(bz), 32'd0);
    @(negedge clk_i);
    chk("g_busy_after", 32'(busy_o), 32'd1);
    chk("g_done_after", 32'(done_o), 32'd0);
    wait_end(300, cyc);
    chk("g_done2", 32'(done_o), 32'd1);
    chk("g_len", 32'(log_q.size()), 32'd5);
    if (log_q.size() > 0) chk("g_first_is_read", 32'(log_q[0].w), 32'd0);
    check_seq(1, 3, 1);

    // Reset pulse while entry 1 is waiting: restart from entry 0.
    fixed_wait = 2;
    do_reset();
    repeat (6) @(negedge clk_i);
    chk("h_mid_len", 32'(log_q.size()), 32'd1);
    chk("h_mid_addr", cfg_addr_o, 32'h1);
    #1 rst_i = 1;
    #1;
    chk("h_rst_valid", 32'(cfg_valid_o), 32'd0);
    chk("h_rst_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    rst_i = 0;
    log_q.delete();
    wait_end(200, cyc);
    chk("h_lat", 32'(cyc), 32'd13);
    chk("h_len", 32'(log_q.size()), 32'd4);
    check_seq(0, 3, 1);

    for (int it = 0; it < 8; it++) begin
      fixed_wait = -1;
      wait_max   = int'($urandom_range(0, 3));
      fail_polls = int'($urandom_range(0, 10));
      err_en     = ($urandom_range(0, 3) == 0);
      k          = int'($urandom_range(0, 3));
      err_addr   = (k == 3) ? PA : 32'(k);
      if (err_en && err_addr != PA) begin
        nw = k + 1; nr = 0; efail = 1; eidx = k;
      end else if (err_en) begin
        nw = N; nr = 1; efail = 1; eidx = N;
      end else begin
        nw = N; nr = (fail_polls + 1 < MP) ? fail_polls + 1 : MP;
        efail = (fail_polls >= MP); eidx = efail ? N : 0;
      end
      do_reset();
      wait_end(500, cyc);
      repeat (3) @(negedge clk_i);
      chk("r_error", 32'(error_o), 32'(efail));
      chk("r_done", 32'(done_o), 32'(!efail));
      chk("r_err_idx", 32'(err_idx_o), 32'(eidx));
      chk("r_len", 32'(log_q.size()), 32'(nw + nr));
      check_seq(0, nw, nr);
      for (int t = 0; t < 2; t++) begin
        k    = 8 + int'($urandom_range(0, 7));
        data = $urandom;
        soc_xfer(1'b1, 32'(k), data, rd, er, n, bz);
        chk("r_wr_err", 32'(er), 32'd0);
        soc_xfer(1'b0, 32'(k), 32'h0, rd, er, n, bz);
        chk("r_readback", rd, data);
      end
      err_en = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
